// File: rtl/noc_pkg.sv
// Shared types and defaults for the ring router arbitration blocks.
package noc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int ARB_N = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching from ptr upward, wrapping.
module rr_pick
  import noc_pkg::*;
#(
  parameter int N    = ARB_N,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;

  // Low half holds requests at or above ptr, high half the full vector,
  // so the lowest set bit of the pair is the wrapped round-robin winner.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    dbl    = {req, req & mask};
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!any && dbl[i]) begin
        any    = 1'b1;
        gnt_id = ID_W'(i % N);
      end
    end
    if (any) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_lock.sv
// N-way round-robin arbiter that holds the grant on one port until its tail flit transfers.
module rr_arbiter_lock
  import noc_pkg::*;
#(
  parameter int N    = ARB_N,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    last,
  input  logic            ready,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id
);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;

  logic [N-1:0]    pick_gnt;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;

  logic [N-1:0]    gnt_raw;
  logic [ID_W-1:0] id_raw;
  logic            valid_raw;
  logic            tail;

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + 1'b1;
  endfunction

  rr_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .gnt    (pick_gnt),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // Grant depends only on req and registered state; ready/last only steer the next state.
  always_comb begin
    gnt_raw = '0;
    id_raw  = '0;
    if (state_q == IDLE) begin
      gnt_raw = pick_gnt;
      id_raw  = pick_id;
    end else if (req[owner_q]) begin
      gnt_raw[owner_q] = 1'b1;
      id_raw           = owner_q;
    end
    valid_raw = |gnt_raw;
    tail      = valid_raw && ready && last[id_raw];

    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          if (tail) begin
            ptr_d = next_idx(pick_id);
          end else begin
            state_d = LOCKED;
            owner_d = pick_id;
          end
        end
      end
      LOCKED: begin
        if (tail) begin
          state_d = IDLE;
          ptr_d   = next_idx(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign gnt       = reset ? '0 : gnt_raw;
  assign gnt_valid = reset ? 1'b0 : valid_raw;
  assign gnt_id    = reset ? '0 : id_raw;

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Directed scoreboard bench for rr_arbiter_lock (N=4): driver queues expectations, monitor checks.
module tb_rr_arbiter_lock;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic            ready;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;

  typedef struct {
    logic [N-1:0]    gnt;
    logic            valid;
    logic [ID_W-1:0] id;
    string           name;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter_lock #(
    .N    (N),
    .ID_W (ID_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .ready     (ready),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  function automatic logic [ID_W-1:0] idx_of(input logic [N-1:0] oh);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (oh[i]) r = ID_W'(i);
    return r;
  endfunction

  task automatic check(input exp_t e);
    total++;
    if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id) begin
      bad++;
      $display("FAIL %s: got gnt=%b valid=%b id=%0d, want gnt=%b valid=%b id=%0d",
               e.name, gnt, gnt_valid, gnt_id, e.gnt, e.valid, e.id);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle away from the rising edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) check(sb_q.pop_front());
  end

  // Apply one cycle of inputs just after the rising edge and queue the expected grant.
  task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic rdy, input logic [N-1:0] exp_gnt, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    req   = r;
    last  = l;
    ready = rdy;
    e.gnt   = exp_gnt;
    e.valid = |exp_gnt;
    e.id    = idx_of(exp_gnt);
    e.name  = name;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    last  = '0;
    ready = 1'b0;

    // Reset forces outputs low even with requests pending
    step(1, 4'b1111, 4'b1111, 1, 4'b0000, "reset_outputs");

    // Rotation: single-flit packets from all ports
    step(0, 4'b1111, 4'b1111, 1, 4'b0001, "rot0");
    step(0, 4'b1111, 4'b1111, 1, 4'b0010, "rot1");
    step(0, 4'b1111, 4'b1111, 1, 4'b0100, "rot2");
    step(0, 4'b1111, 4'b1111, 1, 4'b1000, "rot3");
    step(0, 4'b1111, 4'b1111, 1, 4'b0001, "rot4");

    // Lock: port 0 sends 3 flits; last on non-granted port 2 is ignored
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, "reset_lock");
    step(0, 4'b0101, 4'b0100, 1, 4'b0001, "lock_f1");
    step(0, 4'b0101, 4'b0100, 1, 4'b0001, "lock_f2");
    step(0, 4'b0101, 4'b0001, 1, 4'b0001, "lock_f3_tail");
    step(0, 4'b0101, 4'b0100, 1, 4'b0100, "lock_next_no_bubble");
    step(0, 4'b0101, 4'b0101, 1, 4'b0001, "lock_after_ptr3");

    // Backpressure: port 1 granted with ready low, port 0 arrives meanwhile
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, "reset_bp");
    step(0, 4'b0010, 4'b0010, 0, 4'b0010, "bp_stall1");
    step(0, 4'b0011, 4'b0010, 0, 4'b0010, "bp_stall2");
    step(0, 4'b0011, 4'b0010, 1, 4'b0010, "bp_tail");
    step(0, 4'b1001, 4'b1001, 1, 4'b1000, "bp_search_3_before_0");
    step(0, 4'b0001, 4'b0001, 1, 4'b0001, "bp_port0");

    // Wrap: tail on port 3 sets ptr to 0, then port 0 tail sets ptr to 1
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, "reset_wrap");
    step(0, 4'b1000, 4'b1000, 1, 4'b1000, "wrap_p3");
    step(0, 4'b1001, 4'b1001, 1, 4'b0001, "wrap_p0");
    step(0, 4'b0011, 4'b0011, 1, 4'b0010, "wrap_ptr_is_1");

    // Owner drop: port 2 locked, withdraws for 2 cycles while port 1 waits
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, "reset_drop");
    step(0, 4'b0100, 4'b0000, 1, 4'b0100, "drop_lock_p2");
    step(0, 4'b0010, 4'b0010, 1, 4'b0000, "drop_hold1");
    step(0, 4'b0010, 4'b0010, 1, 4'b0000, "drop_hold2");
    step(0, 4'b0110, 4'b0000, 1, 4'b0100, "drop_resume");
    step(0, 4'b0110, 4'b0100, 1, 4'b0100, "drop_tail");
    step(0, 4'b0010, 4'b0010, 1, 4'b0010, "drop_p1_served");

    // Reset mid-packet while port 3 holds the lock
    step(1, 4'b0000, 4'b0000, 0, 4'b0000, "reset_mid");
    step(0, 4'b1000, 4'b0000, 1, 4'b1000, "mid_lock_p3");
    step(0, 4'b1000, 4'b0000, 1, 4'b1000, "mid_flit2");
    step(1, 4'b1000, 4'b0000, 1, 4'b0000, "mid_reset_cycle");
    step(0, 4'b1010, 4'b0000, 1, 4'b0010, "mid_after_reset_ptr0");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_lock.md
# rr_arbiter_lock

Parametrised N-way round-robin arbiter with packet locking, used at each ring router output port to pick among the local injection port and upstream channels. A winner holds the grant, with no preemption, until it transfers a flit marked `last` while `ready` is high. Rotation then resumes at the port after the one that just finished. Grant decisions are combinational from `req`. Lock and rotation state are registered.

## Interface
- `N`, default 4: number of requesters; N ≥ 2.
- `ID_W`, default `$clog2(N)`: width of the grant index.

- `clk`  input  1  — the single clock; all state updates on its rising edge.
- `reset`  input  1  — synchronous, active-high; acts on the rising edge of `clk` while high.
- `req`  input  N  — per-port request; bit i is port i.
- `last`  input  N  — per-port tail-flit marker; bit i is only meaningful while `req[i]` is high.
- `ready`  input  1  — downstream accepts a flit this cycle.
- `gnt`  output  N  — one-hot grant, or all zero.
- `gnt_valid`  output  1  — OR-reduction of `gnt`.
- `gnt_id`  output  ID_W  — binary index of the granted port; 0 when `gnt_valid` is 0.

## Operation
- States: IDLE and LOCKED. Registers: `state`, `ptr` (ID_W bits), `owner` (ID_W bits).
- Reset values: state=IDLE, ptr=0, owner=0.
- While `reset` is high, `gnt`, `gnt_valid` and `gnt_id` are forced to 0.
- **IDLE:**
  - The winner is the first set bit of `req`, searching ptr, ptr+1, …, N−1, 0, …, ptr−1.
  - `gnt` is the one-hot code of the winner. `gnt` is 0 if `req` is 0.
- **LOCKED:** `gnt = onehot(owner) & req`. Other requests are ignored.
  - If the owner drops `req`, the lock is held with `gnt`=0. Nobody else is served.
- A transfer happens when `gnt_valid && ready`. A tail transfer is a transfer with `last[gnt_id]` high.
- Transitions:
  - IDLE, winner exists, tail transfer: stay IDLE; ptr ← (winner+1) mod N.
  - IDLE, winner exists, no tail transfer (non-tail flit, or `ready` low): → LOCKED; owner ← winner; ptr unchanged. The grant stays stable under backpressure.
  - IDLE, no request: no change.
  - LOCKED, tail transfer: → IDLE; ptr ← (owner+1) mod N.
  - LOCKED, otherwise: no change.
- Wrap-around: when owner = N−1, ptr ← 0. For non-power-of-two N, ptr never holds a value ≥ N.
- `last` on a non-granted port has no effect.
- Reset mid-packet: the lock is dropped; the next cycle is IDLE with ptr=0.

## Timing
- Grant latency is 0 cycles: `gnt` is valid in the same cycle that `req` rises, if the arbiter is IDLE.
- `gnt` is combinational from `req`, `state`, `ptr` and `owner`. It never depends combinationally on `ready` or `last`, so there is no loop through downstream flow control.
- Single-flit packet (tail on the first transfer): occupies 1 cycle; the next port can be granted in the following cycle.
- Back-to-back packets from different ports have no bubble cycle.
- A k-flit packet with `ready` held high keeps `gnt` one-hot on the owner for exactly k cycles.
- Fairness: with all N requesters continuously active, each port is served once every N packets.

## Structure
- Shared package `noc_pkg`:
  - `arb_state_t` enum {IDLE, LOCKED}.
  - Default `ARB_N` = 4.
- Sub-module `rr_pick` (combinational):
  - Inputs: `req`[N], `ptr`[ID_W].
  - Outputs: `gnt`[N], `gnt_id`, `any`.
  - Implementation: double-width masked priority encoder.
  - Reused by the ring VC allocator.
- Top level holds the state register, the ptr/owner registers and the output masking.

## Test plan
- **Rotation:** N=4; release reset; hold req=4'b1111, last=4'b1111, ready=1 → `gnt_id` = 0,1,2,3,0 on consecutive cycles.
- **Lock:**
  - Stimulus: req=4'b0101; port 0 sends 3 flits (last on the 3rd); ready=1.
  - Required: gnt=4'b0001 for 3 cycles, then 4'b0100 on the 4th cycle with no bubble.
- **Backpressure:**
  - Stimulus: port 1 is granted from IDLE with ready=0 for 2 cycles; req[0] rises in cycle 2.
  - Required: gnt stays 4'b0010; when ready=1 with last[1] high, the next grant goes to port 0 only if port 2/3 are idle (ptr=2 search order: 2, 3, 0).
- **Wrap:** finish a packet on port 3, then req=4'b1001 → gnt=4'b0001; ptr after that tail transfer = 1.
- **Owner drop:**
  - Stimulus: port 2 is LOCKED; req[2] goes low for 2 cycles while req[1]=1.
  - Required: gnt=0 and gnt_valid=0 for those cycles; port 2 resumes and finishes; port 1 is served afterwards.
- **Reset mid-packet:**
  - Stimulus: assert reset for 1 cycle while port 3 is LOCKED.
  - Required: outputs are 0 during the reset cycle; next cycle is IDLE; req=4'b1010 → gnt=4'b0010 (ptr=0).
